// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: round-robin owner of the single system-bus port.
// Masters raise busreq (level). The arbiter grants one master at a time and
// follows that master's busidle to learn when its transaction starts and ends.
// Index 0 is the icache, index 1 the dcache, further indices are other masters.
//
// Handshake: in ARB a request is a level sampled on each clock edge. A grant is a
// registered one-hot pulse that lasts from the arbitration edge until the owner
// drives its busidle low. The grant drops at that point, so the master cannot
// start a second transaction on the same grant. The bus is released on the
// first edge that sees the owner's busidle high again. One dead ARB cycle always
// separates two ownerships.
//
// Optional feature: define SYSBUS_ARB_WATCHDOG_EN to revoke a grant whose owner
// never starts its transaction within TIMEOUT cycles. grant_timeout then pulses
// for one cycle. Without the macro the watchdog counter is not built and
// grant_timeout is tied low.
module sysbus_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] busreq,
   input  logic [NUM_REQ-1:0] busidle,
   output logic [NUM_REQ-1:0] busgrant,
   output logic [IDX_W-1:0]   bus_owner,
   output logic               bus_busy,
   output logic               grant_timeout
);

   // Parameter sanity: the owner index must address every master, and the
   // watchdog counter must be able to reach TIMEOUT-1.
   if (NUM_REQ < 2 || (1 << IDX_W) < NUM_REQ) begin : g_bad_idx_w
      $error("sysbus_arbiter: IDX_W too small for NUM_REQ");
   end
   if (TIMEOUT < 2 || (1 << TO_W) <= TIMEOUT) begin : g_bad_to_w
      $error("sysbus_arbiter: TO_W cannot hold TIMEOUT");
   end

   // ARB: waiting for requests; GRANT: grant issued, owner not started yet;
   // BUSY: owner is running its bus transaction.
   typedef enum logic [1:0] {
      ARB   = 2'd0,
      GRANT = 2'd1,
      BUSY  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [NUM_REQ-1:0] grant_nxt;
   logic [IDX_W-1:0]   owner_nxt;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   rr_nxt;
   logic [IDX_W-1:0]   owner_inc;
   logic [IDX_W-1:0]   winner;
   logic               win_found;
   logic               owner_idle;
   int                 scan_idx;

`ifdef SYSBUS_ARB_WATCHDOG_EN
   logic [TO_W-1:0]    wd_cnt;
   logic [TO_W-1:0]    wd_nxt;
   logic               wd_expired;
   logic               timeout_nxt;
`endif

   // The owner's idle flag; idle flags of non-owners play no part.
   assign owner_idle = busidle[bus_owner];

   // Next round-robin start point: one past the current owner, wrapping at NUM_REQ.
   assign owner_inc = (bus_owner == IDX_W'(NUM_REQ - 1)) ? '0 : bus_owner + IDX_W'(1);

   // Round-robin pick: nearest requesting index at or above rr_ptr, with wrap.
   // Scanning from the far end down lets the closest match win by overwriting.
   always_comb begin
      winner    = '0;
      win_found = 1'b0;
      scan_idx  = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         scan_idx = (int'(rr_ptr) + i) % NUM_REQ;
         if (busreq[scan_idx]) begin
            winner    = IDX_W'(scan_idx);
            win_found = 1'b1;
         end
      end
   end

`ifdef SYSBUS_ARB_WATCHDOG_EN
   // Watchdog count: zero outside GRANT, so it restarts on every entry to GRANT.
   always_comb begin
      wd_nxt     = '0;
      wd_expired = (wd_cnt == TO_W'(TIMEOUT - 1));
      if (state == GRANT) begin
         wd_nxt = wd_cnt + TO_W'(1);
      end
   end
`endif

   // Next-state and registered-output values of the arbitration FSM.
   always_comb begin
      state_nxt = state;
      grant_nxt = busgrant;
      owner_nxt = bus_owner;
      rr_nxt    = rr_ptr;
`ifdef SYSBUS_ARB_WATCHDOG_EN
      timeout_nxt = 1'b0;
`endif
      unique case (state)
         ARB: begin
            grant_nxt = '0;
            if (win_found) begin
               grant_nxt[winner] = 1'b1;
               owner_nxt         = winner;
               state_nxt         = GRANT;
            end
         end
         GRANT: begin
            if (!owner_idle) begin
               // Owner has started; drop the grant so it cannot re-issue.
               grant_nxt = '0;
               state_nxt = BUSY;
            end
`ifdef SYSBUS_ARB_WATCHDOG_EN
            else if (wd_expired) begin
               // Stale grant: revoke it and let the next master in.
               grant_nxt   = '0;
               timeout_nxt = 1'b1;
               rr_nxt      = owner_inc;
               state_nxt   = ARB;
            end
`endif
         end
         BUSY: begin
            grant_nxt = '0;
            if (owner_idle) begin
               rr_nxt    = owner_inc;
               state_nxt = ARB;
            end
         end
         default: begin
            grant_nxt = '0;
            state_nxt = ARB;
         end
      endcase
   end

   // State register and registered outputs; reset drops any grant at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ARB;
         busgrant  <= '0;
         bus_owner <= '0;
         bus_busy  <= 1'b0;
         rr_ptr    <= '0;
      end else begin
         state     <= state_nxt;
         busgrant  <= grant_nxt;
         bus_owner <= owner_nxt;
         bus_busy  <= (state_nxt != ARB);
         rr_ptr    <= rr_nxt;
      end
   end

`ifdef SYSBUS_ARB_WATCHDOG_EN
   // Watchdog counter and the one-cycle revoke pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt        <= '0;
         grant_timeout <= 1'b0;
      end else begin
         wd_cnt        <= wd_nxt;
         grant_timeout <= timeout_nxt;
      end
   end
`else
   assign grant_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: directed scenarios followed by randomized masters.
// A reference model predicts, edge by edge, which master owns the bus and when
// each grant is issued; predicted grants are queued and a monitor pops them.
// Honours SYSBUS_ARB_WATCHDOG_EN the same way the design does.
module tb_sysbus_arbiter;
   localparam int NUM_REQ = 2;
   localparam int IDX_W   = 1;
   localparam int TIMEOUT = 16;
   localparam int TO_W    = 5;

   logic               clk   = 1'b0;
   logic               reset = 1'b1;
   logic [NUM_REQ-1:0] busreq;
   logic [NUM_REQ-1:0] busidle;
   logic [NUM_REQ-1:0] busgrant;
   logic [IDX_W-1:0]   bus_owner;
   logic               bus_busy;
   logic               grant_timeout;

   int total = 0;
   int bad   = 0;

   logic [NUM_REQ-1:0] exp_q[$];

   // Reference model state: phase 0 = bus free, 1 = granted, 2 = owner running.
   int   m_phase = 0;
   int   m_owner = 0;
   int   m_rr    = 0;
   int   m_cyc   = 0;
   int   m_gcyc  = 0;
   logic m_to_exp = 1'b0;

   sysbus_arbiter #(
      .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
   ) dut (
      .clk(clk), .reset(reset), .busreq(busreq), .busidle(busidle),
      .busgrant(busgrant), .bus_owner(bus_owner), .bus_busy(bus_busy),
      .grant_timeout(grant_timeout)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_grant(input string name, output int idx);
      idx = -1;
      for (int n = 0; n < 40 && idx < 0; n++) begin
         tick();
         for (int i = 0; i < NUM_REQ; i++) if (busgrant[i]) idx = i;
      end
      if (idx < 0) fail_now(name);
   endtask

   // Owner runs a transaction: busidle low for busy_cycles, then high again.
   task automatic run_xfer(input int idx, input int busy_cycles);
      busidle[idx] = 1'b0;
      repeat (busy_cycles) tick();
      busidle[idx] = 1'b1;
   endtask

   // Reference model, applied on each active edge using the inputs seen there.
   int  mj;
   bit  mfound;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase  = 0;
         m_owner  = 0;
         m_rr     = 0;
         m_to_exp = 1'b0;
         exp_q.delete();
      end else begin
         m_cyc++;
         m_to_exp = 1'b0;
         if (m_phase == 0) begin
            mfound = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
               mj = (m_rr + k) % NUM_REQ;
               if (!mfound && busreq[mj]) begin
                  mfound  = 1;
                  m_owner = mj;
               end
            end
            if (mfound) begin
               m_phase = 1;
               m_gcyc  = m_cyc;
               exp_q.push_back(NUM_REQ'(1) << m_owner);
            end
         end else if (m_phase == 1) begin
            if (!busidle[m_owner]) m_phase = 2;
`ifdef SYSBUS_ARB_WATCHDOG_EN
            else if (m_cyc - m_gcyc == TIMEOUT) begin
               m_phase  = 0;
               m_rr     = (m_owner + 1) % NUM_REQ;
               m_to_exp = 1'b1;
            end
`endif
         end else begin
            if (busidle[m_owner]) begin
               m_phase = 0;
               m_rr    = (m_owner + 1) % NUM_REQ;
            end
         end
      end
   end

   // Monitor: pops a predicted grant on each new grant, checks status every cycle.
   logic [NUM_REQ-1:0] prev_grant = '0;
   logic [NUM_REQ-1:0] eg;
   logic [NUM_REQ-1:0] popped;
   always @(negedge clk) begin
      if (reset) begin
         prev_grant = '0;
      end else begin
         if (busgrant != '0 && prev_grant == '0) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_grant", 32'(busgrant), 32'd0);
            end else begin
               popped = exp_q.pop_front();
               chk("sb_grant", 32'(busgrant), 32'(popped));
            end
         end
         eg = (m_phase == 1) ? (NUM_REQ'(1) << m_owner) : '0;
         chk("mon_grant", 32'(busgrant), 32'(eg));
         chk("mon_onehot", ($countones(busgrant) <= 1), 32'd1);
         chk("mon_busy", 32'(bus_busy), 32'(m_phase != 0));
         chk("mon_timeout", 32'(grant_timeout), 32'(m_to_exp));
         if (m_phase != 0) chk("mon_owner", 32'(bus_owner), 32'(m_owner));
         prev_grant = busgrant;
      end
   end

   // Global time bound.
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "time bound");
   end

   int g;
   int st[NUM_REQ];
   int cnt[NUM_REQ];
   int wt[NUM_REQ];
   bit all_idle;

   initial begin
      busreq  = '0;
      busidle = '1;
      tick();
      tick();
      chk("reset_grant", 32'(busgrant), 32'd0);
      chk("reset_owner", 32'(bus_owner), 32'd0);
      chk("reset_busy", 32'(bus_busy), 32'd0);
      chk("reset_timeout", 32'(grant_timeout), 32'd0);
      reset = 1'b0;
      tick();

      // Single master, cycle-exact timing.
      busreq = 2'b01;
      tick();
      chk("t2_grant", 32'(busgrant), 32'h1);
      chk("t2_owner", 32'(bus_owner), 32'd0);
      busreq = 2'b00;
      tick();
      chk("t2_hold", 32'(busgrant), 32'h1);
      tick();
      busidle[0] = 1'b0;
      tick();
      chk("t2_drop", 32'(busgrant), 32'd0);
      chk("t2_busy", 32'(bus_busy), 32'd1);
      repeat (6) tick();
      busidle[0] = 1'b1;
      tick();
      chk("t2_release", 32'(bus_busy), 32'd0);
      tick();

      // Reset while master 1 is mid-transaction.
      busreq = 2'b10;
      wait_grant("t1_wait", g);
      chk("t1_granted", g, 1);
      busreq = 2'b00;
      busidle[1] = 1'b0;
      tick();
      tick();
      chk("t1_in_busy", 32'(bus_busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("t1_rst_grant", 32'(busgrant), 32'd0);
      chk("t1_rst_busy", 32'(bus_busy), 32'd0);
      chk("t1_rst_owner", 32'(bus_owner), 32'd0);
      busidle = '1;
      tick();
      reset = 1'b0;
      tick();
      chk("t1_after_busy", 32'(bus_busy), 32'd0);
      chk("t1_after_owner", 32'(bus_owner), 32'd0);

      // Tie and fairness: both request continuously.
      busreq = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_grant("t3_wait", g);
         chk("t3_order", g, k % 2);
         if (g >= 0) begin
            tick();
            run_xfer(g, 2);
         end
      end
      busreq = 2'b00;
      repeat (3) tick();

      // Pending request raised during another master's transaction.
      busreq = 2'b10;
      wait_grant("t4_wait", g);
      chk("t4_first", g, 1);
      busreq = 2'b00;
      busidle[1] = 1'b0;
      tick();
      tick();
      busreq[0] = 1'b1;
      tick();
      busidle[1] = 1'b1;
      tick();
      chk("t4_dead_cycle", 32'(busgrant), 32'd0);
      tick();
      chk("t4_pending_grant", 32'(busgrant), 32'h1);
      busreq = 2'b00;
      run_xfer(0, 2);
      repeat (3) tick();

      // Stale grant: master 0 never starts, master 1 waits.
      busreq = 2'b01;
      wait_grant("t5_wait", g);
      chk("t5_first", g, 0);
      busreq = 2'b10;
`ifdef SYSBUS_ARB_WATCHDOG_EN
      for (int k = 1; k < TIMEOUT; k++) begin
         tick();
         chk("t5_hold", 32'(busgrant), 32'h1);
         chk("t5_no_pulse", 32'(grant_timeout), 32'd0);
      end
      tick();
      chk("t5_pulse", 32'(grant_timeout), 32'd1);
      chk("t5_revoked", 32'(busgrant), 32'd0);
      tick();
      chk("t5_pulse_end", 32'(grant_timeout), 32'd0);
      chk("t5_next_grant", 32'(busgrant), 32'h2);
      busreq = 2'b00;
      run_xfer(1, 2);
`else
      for (int k = 0; k < 100; k++) begin
         tick();
         chk("t6_hold", 32'(busgrant), 32'h1);
         chk("t6_no_pulse", 32'(grant_timeout), 32'd0);
      end
      run_xfer(0, 1);
      wait_grant("t6_wait", g);
      chk("t6_next", g, 1);
      busreq = 2'b00;
      run_xfer(1, 1);
`endif
      repeat (3) tick();

      // Randomized masters; each behaves as a well-formed bus master.
      for (int i = 0; i < NUM_REQ; i++) begin
         st[i]  = 0;
         cnt[i] = $urandom_range(0, 4);
         wt[i]  = 0;
      end
      for (int c = 0; c < 4000; c++) begin
         tick();
         all_idle = 1;
         for (int i = 0; i < NUM_REQ; i++) begin
            case (st[i])
               0: begin
                  if (c < 3500) begin
                     if (cnt[i] == 0) begin
                        busreq[i] = 1'b1;
                        st[i]     = 1;
                        wt[i]     = 0;
                     end else cnt[i]--;
                  end
               end
               1: begin
                  if (busgrant[i]) begin
                     busreq[i] = 1'b0;
                     st[i]     = 2;
                     cnt[i]    = $urandom_range(0, 3);
                  end else if (++wt[i] > 100) begin
                     fail_now("rand_req_starved");
                     busreq[i] = 1'b0;
                     st[i]     = 0;
                     cnt[i]    = 0;
                  end
               end
               2: begin
                  if (cnt[i] == 0) begin
                     busidle[i] = 1'b0;
                     st[i]      = 3;
                     cnt[i]     = $urandom_range(1, 5);
                  end else cnt[i]--;
               end
               default: begin
                  if (cnt[i] == 0) begin
                     busidle[i] = 1'b1;
                     st[i]      = 0;
                     cnt[i]     = $urandom_range(0, 6);
                  end else cnt[i]--;
               end
            endcase
            if (st[i] != 0) all_idle = 0;
         end
         if (c >= 3500 && all_idle) break;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (st[i] != 0) fail_now("rand_drain");
      end
      busreq  = '0;
      busidle = '1;
      repeat (4) tick();
      chk("end_queue_empty", exp_q.size(), 0);
      chk("end_idle", 32'(bus_busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
